// File: rtl/audio_pkg.sv
// Shared audio definitions: tone FSM states, default note/gap lengths,
// the 25 MHz tone table used by the tone decoder, and a counter-width helper.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_t;

    localparam int DEFAULT_NOTE_CYCLES = 5_000_000;  // 200 ms @ 25 MHz
    localparam int DEFAULT_GAP_CYCLES  = 500_000;    // 20 ms @ 25 MHz

    // Prescale words for a 25 MHz clock (freq = clk / (256 * word))
    localparam logic [9:0] TONE_DO = 10'h175;
    localparam logic [9:0] TONE_MI = 10'h128;
    localparam logic [9:0] TONE_LA = 10'h0DD;

    // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit
    function automatic int cntWidth(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/tone_player_prescaler.sv
// Tone prescaler: divides the clock by 'divisor' and advances a phase
// counter once per divided tick. 'clear' has priority over 'run' so the
// owner can restart a note on the same edge it latches a new divisor.
module tone_prescaler #(
    parameter int PRESCALE_W = 10,
    parameter int PHASE_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] divisor,
    output logic [PHASE_W-1:0]    phase
);

    logic [PRESCALE_W-1:0] preCnt_r;
    logic [PHASE_W-1:0]    phase_r;
    logic                  terminal_s;

    // Terminal count of the prescaler (divisor of 1 makes every cycle terminal)
    always_comb begin
        terminal_s = 1'b0;
        if (preCnt_r == (divisor - PRESCALE_W'(1))) begin
            terminal_s = 1'b1;
        end else begin
            terminal_s = 1'b0;
        end
    end

    // Prescale counter wraps at divisor-1 and steps the phase (mod 2^PHASE_W)
    always_ff @(posedge clk) begin
        if (reset) begin
            preCnt_r <= {PRESCALE_W{1'b0}};
            phase_r  <= {PHASE_W{1'b0}};
        end else if (clear) begin
            preCnt_r <= {PRESCALE_W{1'b0}};
            phase_r  <= {PHASE_W{1'b0}};
        end else if (run) begin
            if (terminal_s) begin
                preCnt_r <= {PRESCALE_W{1'b0}};
                phase_r  <= phase_r + PHASE_W'(1);
            end else begin
                preCnt_r <= preCnt_r + PRESCALE_W'(1);
            end
        end else begin
            preCnt_r <= preCnt_r;
            phase_r  <= phase_r;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/tone_player.sv
// Tone player: turns a one-cycle nonzero prescale request into a timed
// square-wave note followed by a short silent gap. Holds the IDLE/PLAY/GAP
// FSM, the latched prescale word and the shared duration counter; the
// prescaler sub-module generates the phase.
module tone_player
    import audio_pkg::*;
#(
    parameter int PRESCALE_W  = 10,
    parameter int PHASE_W     = 8,
    parameter int NOTE_CYCLES = DEFAULT_NOTE_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] preScaleValue,
    output logic                  tone_out,
    output logic [PHASE_W-1:0]    phase,
    output logic                  audio_enable,
    output logic                  busy,
    output logic                  note_done
);

    localparam int CNT_W = cntWidth(NOTE_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    tone_state_t           state_r;
    logic [PRESCALE_W-1:0] latched_r;
    logic [CNT_W-1:0]      durCnt_r;
    logic                  audioEnable_r;
    logic                  busy_r;
    logic                  noteDone_r;

    logic                  request_s;
    logic                  load_s;
    logic                  noteExpire_s;
    logic                  clear_s;
    logic                  run_s;
    logic [PHASE_W-1:0]    phase_s;

    // Decode requests, note expiry and prescaler control from current state
    always_comb begin
        request_s    = 1'b0;
        load_s       = 1'b0;
        noteExpire_s = 1'b0;
        run_s        = 1'b0;
        clear_s      = 1'b1;
        if (preScaleValue != {PRESCALE_W{1'b0}}) begin
            request_s = 1'b1;
        end else begin
            request_s = 1'b0;
        end
        if ((state_r == ST_IDLE) || (state_r == ST_PLAY)) begin
            load_s = request_s;
        end else begin
            load_s = 1'b0;   // requests during the gap are dropped
        end
        if ((state_r == ST_PLAY) && (durCnt_r == NOTE_LAST)) begin
            noteExpire_s = 1'b1;
        end else begin
            noteExpire_s = 1'b0;
        end
        // Phase is held at zero outside PLAY and restarted on every load,
        // so it is already zero in the first GAP cycle
        if (state_r == ST_PLAY) begin
            run_s   = 1'b1;
            clear_s = load_s | noteExpire_s;
        end else begin
            run_s   = 1'b0;
            clear_s = 1'b1;
        end
    end

    // Note FSM with latch, duration counter and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            latched_r     <= {PRESCALE_W{1'b0}};
            durCnt_r      <= {CNT_W{1'b0}};
            audioEnable_r <= 1'b0;
            busy_r        <= 1'b0;
            noteDone_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    noteDone_r <= 1'b0;
                    durCnt_r   <= {CNT_W{1'b0}};
                    if (load_s) begin
                        latched_r     <= preScaleValue;
                        state_r       <= ST_PLAY;
                        audioEnable_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end else begin
                        state_r       <= ST_IDLE;
                        audioEnable_r <= 1'b0;
                        busy_r        <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Retrigger takes priority over expiry on the same cycle
                    if (load_s) begin
                        latched_r     <= preScaleValue;
                        durCnt_r      <= {CNT_W{1'b0}};
                        state_r       <= ST_PLAY;
                        audioEnable_r <= 1'b1;
                        busy_r        <= 1'b1;
                        noteDone_r    <= 1'b0;
                    end else if (noteExpire_s) begin
                        durCnt_r      <= {CNT_W{1'b0}};
                        state_r       <= ST_GAP;
                        audioEnable_r <= 1'b0;
                        busy_r        <= 1'b1;
                        noteDone_r    <= 1'b1;
                    end else begin
                        durCnt_r      <= durCnt_r + CNT_W'(1);
                        state_r       <= ST_PLAY;
                        audioEnable_r <= 1'b1;
                        busy_r        <= 1'b1;
                        noteDone_r    <= 1'b0;
                    end
                end
                ST_GAP: begin
                    audioEnable_r <= 1'b0;
                    noteDone_r    <= 1'b0;
                    if (durCnt_r == GAP_LAST) begin
                        durCnt_r <= {CNT_W{1'b0}};
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                    end else begin
                        durCnt_r <= durCnt_r + CNT_W'(1);
                        state_r  <= ST_GAP;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    durCnt_r      <= {CNT_W{1'b0}};
                    audioEnable_r <= 1'b0;
                    busy_r        <= 1'b0;
                    noteDone_r    <= 1'b0;
                end
            endcase
        end
    end

    tone_prescaler #(
        .PRESCALE_W (PRESCALE_W),
        .PHASE_W    (PHASE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .run     (run_s),
        .divisor (latched_r),
        .phase   (phase_s)
    );

    assign phase        = phase_s;
    assign tone_out     = phase_s[PHASE_W-1];
    assign audio_enable = audioEnable_r;
    assign busy         = busy_r;
    assign note_done    = noteDone_r;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with NOTE_CYCLES=10000, GAP_CYCLES=100.
// Inputs change and outputs are sampled on the falling edge.
module tb_tone_player;
    import audio_pkg::*;

    logic       clk;
    logic       reset;
    logic [9:0] preScaleValue;
    logic       tone_out;
    logic [7:0] phase;
    logic       audio_enable;
    logic       busy;
    logic       note_done;

    int nChecks;
    int nBad;
    int doneCount;
    int firstDone;

    tone_player #(
        .PRESCALE_W  (10),
        .PHASE_W     (8),
        .NOTE_CYCLES (10000),
        .GAP_CYCLES  (100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .preScaleValue (preScaleValue),
        .tone_out      (tone_out),
        .phase         (phase),
        .audio_enable  (audio_enable),
        .busy          (busy),
        .note_done     (note_done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks = nChecks + 1;
        if (got !== exp) begin
            nBad = nBad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkSilent(input string tag);
        checkVal({tag, ".tone"}, 32'(tone_out), 32'd0);
        checkVal({tag, ".phase"}, 32'(phase), 32'd0);
        checkVal({tag, ".aen"}, 32'(audio_enable), 32'd0);
        checkVal({tag, ".busy"}, 32'(busy), 32'd0);
        checkVal({tag, ".done"}, 32'(note_done), 32'd0);
    endtask

    // Drive a one-cycle request; returns in PLAY cycle 1
    task automatic pulse(input logic [9:0] v);
        preScaleValue = v;
        step(1);
        preScaleValue = 10'h000;
    endtask

    initial begin
        nChecks       = 0;
        nBad          = 0;
        reset         = 1'b1;
        preScaleValue = 10'h000;
        step(3);
        checkSilent("reset");
        reset = 1'b0;
        step(5);
        checkSilent("idle");

        // Basic note, divisor 4: phase = floor((k-1)/4) mod 256 in PLAY cycle k
        pulse(10'h004);
        checkVal("n1.aen1", 32'(audio_enable), 32'd1);
        checkVal("n1.busy1", 32'(busy), 32'd1);
        checkVal("n1.phase1", 32'(phase), 32'd0);
        step(511);                                    // k=512
        checkVal("n1.tone512", 32'(tone_out), 32'd0);
        checkVal("n1.phase512", 32'(phase), 32'd127);
        step(1);                                      // k=513
        checkVal("n1.tone513", 32'(tone_out), 32'd1);
        checkVal("n1.phase513", 32'(phase), 32'd128);
        step(512);                                    // k=1025
        checkVal("n1.tone1025", 32'(tone_out), 32'd0);
        checkVal("n1.phase1025", 32'(phase), 32'd0);
        step(8975);                                   // k=10000
        checkVal("n1.aen10000", 32'(audio_enable), 32'd1);
        checkVal("n1.done10000", 32'(note_done), 32'd0);
        checkVal("n1.phase10000", 32'(phase), 32'd195);
        step(1);                                      // first GAP cycle
        checkVal("n1.done", 32'(note_done), 32'd1);
        checkVal("n1.aenGap", 32'(audio_enable), 32'd0);
        checkVal("n1.busyGap", 32'(busy), 32'd1);
        checkVal("n1.phaseGap", 32'(phase), 32'd0);
        step(1);
        checkVal("n1.doneOnce", 32'(note_done), 32'd0);
        step(98);                                     // last GAP cycle
        checkVal("n1.busyLast", 32'(busy), 32'd1);
        step(1);
        checkVal("n1.busyDrop", 32'(busy), 32'd0);
        step(3);

        // Retrigger at PLAY cycle 5000 with divisor 2
        pulse(10'h004);
        step(4999);                                   // k=5000
        preScaleValue = 10'h002;
        step(1);                                      // R+1
        preScaleValue = 10'h000;
        checkVal("rt.phase1", 32'(phase), 32'd0);
        checkVal("rt.aen1", 32'(audio_enable), 32'd1);
        step(255);                                    // R+256
        checkVal("rt.tone256", 32'(tone_out), 32'd0);
        checkVal("rt.phase256", 32'(phase), 32'd127);
        step(1);                                      // R+257
        checkVal("rt.tone257", 32'(tone_out), 32'd1);
        doneCount = 0;
        firstDone = 0;
        for (int j = 258; j <= 10001; j++) begin
            step(1);
            if (note_done) begin
                doneCount = doneCount + 1;
                if (firstDone == 0) firstDone = j;
            end
            if (j == 5001) checkVal("rt.aenOrigExp", 32'(audio_enable), 32'd1);
        end
        checkVal("rt.doneCycle", 32'(firstDone), 32'd10001);
        checkVal("rt.doneCount", 32'(doneCount), 32'd1);
        step(100);
        checkVal("rt.busyDrop", 32'(busy), 32'd0);
        step(2);

        // Request during GAP is dropped
        pulse(10'h004);
        step(10000);                                  // first GAP cycle
        checkVal("gp.done", 32'(note_done), 32'd1);
        step(10);
        pulse(TONE_LA);
        checkVal("gp.aen", 32'(audio_enable), 32'd0);
        checkVal("gp.busy", 32'(busy), 32'd1);
        step(89);                                     // GAP cycle 100 passed
        checkVal("gp.busyDrop", 32'(busy), 32'd0);
        step(5);
        checkVal("gp.noNote", 32'(audio_enable), 32'd0);

        // Retrigger on the expiry cycle
        pulse(10'h004);
        step(9999);                                   // k=10000, dur cnt 9999
        preScaleValue = 10'h004;
        step(1);
        preScaleValue = 10'h000;
        checkVal("ex.done", 32'(note_done), 32'd0);
        checkVal("ex.aen", 32'(audio_enable), 32'd1);
        checkVal("ex.phase", 32'(phase), 32'd0);
        step(9999);
        checkVal("ex.doneEarly", 32'(note_done), 32'd0);
        checkVal("ex.aenLate", 32'(audio_enable), 32'd1);
        step(1);
        checkVal("ex.doneLate", 32'(note_done), 32'd1);
        step(100);
        checkVal("ex.busyDrop", 32'(busy), 32'd0);
        step(2);

        // Divisor 1: phase steps every cycle
        pulse(10'h001);
        checkVal("d1.phase1", 32'(phase), 32'd0);
        step(1);
        checkVal("d1.phase2", 32'(phase), 32'd1);
        step(1);
        checkVal("d1.phase3", 32'(phase), 32'd2);

        // Reset mid-PLAY at cycle 3000
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkSilent("d1rst");
        pulse(10'h004);
        step(2999);                                   // k=3000
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkSilent("mid");
        doneCount = 0;
        for (int j = 0; j < 10200; j++) begin
            step(1);
            if (note_done || audio_enable || busy) doneCount = doneCount + 1;
        end
        checkVal("mid.staysIdle", 32'(doneCount), 32'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
